// File: rtl/fruit_pkg.sv
// Shared constants for the Fruit Ninja score path: FSM encoding and the
// score/lives bus widths (also used by the 7-segment driver's num port).
package fruit_pkg;

    localparam int SCORE_W = 5;
    localparam int LIVES_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } game_state_t;

endpackage

// File: rtl/score_keeper_edge_det.sv
// Two-flop sampler producing a one-cycle rising-edge event from a level input.
module edge_det (
    input  logic ck,
    input  logic rstn,
    input  logic in,
    output logic rise
);

    logic s;
    logic p;

    always_ff @(posedge ck) begin
        if (!rstn) begin
            s <= 1'b0;
            p <= 1'b0;
        end else begin
            s <= in;
            p <= s;
        end
    end

    assign rise = s & ~p;

endmodule

// File: rtl/score_keeper.sv
// Game-score stage: start/hit/miss edges drive an IDLE/PLAY/OVER FSM with a
// saturating score and a lives counter; all outputs are registered.
module score_keeper
    import fruit_pkg::*;
#(
    parameter int MAX_SCORE = 31,
    parameter int LIVES     = 3
) (
    input  logic               ck,
    input  logic               rstn,
    input  logic               start,
    input  logic               hit,
    input  logic               miss,
    output logic [SCORE_W-1:0] num,
    output logic [LIVES_W-1:0] lives,
    output logic               playing,
    output logic               game_over
);

    localparam logic [SCORE_W-1:0] MAX_V   = SCORE_W'(MAX_SCORE);
    localparam logic [LIVES_W-1:0] LIVES_V = LIVES_W'(LIVES);

    logic        start_ev;
    logic        hit_ev;
    logic        miss_ev;
    game_state_t state;

    edge_det u_start (.ck(ck), .rstn(rstn), .in(start), .rise(start_ev));
    edge_det u_hit   (.ck(ck), .rstn(rstn), .in(hit),   .rise(hit_ev));
    edge_det u_miss  (.ck(ck), .rstn(rstn), .in(miss),  .rise(miss_ev));

    always_ff @(posedge ck) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            num       <= '0;
            lives     <= LIVES_V;
            playing   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_OVER: begin
                    // Start takes priority; hit/miss in the same cycle are dropped.
                    if (start_ev) begin
                        state     <= ST_PLAY;
                        num       <= '0;
                        lives     <= LIVES_V;
                        playing   <= 1'b1;
                        game_over <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (hit_ev && (num < MAX_V))
                        num <= num + SCORE_W'(1);
                    if (miss_ev) begin
                        if (lives > LIVES_W'(1)) begin
                            lives <= lives - LIVES_W'(1);
                        end else begin
                            lives     <= '0;
                            state     <= ST_OVER;
                            playing   <= 1'b0;
                            game_over <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    playing   <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Directed and randomized bench for score_keeper against a game-rule model.
module tb_score_keeper;

    logic       ck;
    logic       rstn;
    logic       start;
    logic       hit;
    logic       miss;
    logic [4:0] num;
    logic [1:0] lives;
    logic       playing;
    logic       game_over;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: game mode (0 idle, 1 play, 2 over), score, lives, and
    // the input levels seen at the last two clock edges.
    int m_mode  = 0;
    int m_score = 0;
    int m_lives = 3;
    bit st_last, st_prev, h_last, h_prev, ms_last, ms_prev;

    score_keeper #(.MAX_SCORE(31), .LIVES(3)) dut (
        .ck(ck), .rstn(rstn), .start(start), .hit(hit), .miss(miss),
        .num(num), .lives(lives), .playing(playing), .game_over(game_over)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit st, input bit h, input bit ms);
        bit ev_s, ev_h, ev_m;
        rstn = r; start = st; hit = h; miss = ms;
        @(posedge ck);
        if (!r) begin
            m_mode = 0; m_score = 0; m_lives = 3;
            {st_last, st_prev, h_last, h_prev, ms_last, ms_prev} = '0;
        end else begin
            ev_s = st_last && !st_prev;
            ev_h = h_last && !h_prev;
            ev_m = ms_last && !ms_prev;
            if (m_mode != 1) begin
                if (ev_s) begin
                    m_mode = 1; m_score = 0; m_lives = 3;
                end
            end else begin
                if (ev_h && m_score < 31) m_score = m_score + 1;
                if (ev_m) begin
                    if (m_lives > 1) m_lives = m_lives - 1;
                    else begin
                        m_lives = 0; m_mode = 2;
                    end
                end
            end
            st_prev = st_last; st_last = st;
            h_prev  = h_last;  h_last  = h;
            ms_prev = ms_last; ms_last = ms;
        end
        #1;
        check("num", num, m_score);
        check("lives", lives, m_lives);
        check("playing", playing, (m_mode == 1));
        check("game_over", game_over, (m_mode == 2));
    endtask

    task automatic pulse(input bit st, input bit h, input bit ms);
        cyc(1, st, h, ms);
        cyc(1, 0, 0, 0);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; hit = 1'b0; miss = 1'b0;

        // Reset, then hits in IDLE are ignored.
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("rst_num", num, 0);
        check("rst_lives", lives, 3);
        for (int i = 0; i < 5; i++) pulse(0, 1, 0);
        cyc(1, 0, 0, 0);
        check("idle_hits", num, 0);

        // Start, then playing appears two edges after start rises.
        cyc(1, 1, 0, 0);
        check("play_early", playing, 0);
        cyc(1, 0, 0, 0);
        check("play_2edges", playing, 1);
        for (int i = 1; i <= 7; i++) begin
            cyc(1, 0, 1, 0);
            check("hit_1edge", num, i - 1);
            cyc(1, 0, 0, 0);
            check("hit_2edge", num, i);
        end

        // Held hit counts once.
        for (int i = 0; i < 20; i++) cyc(1, 0, 1, 0);
        cyc(1, 0, 0, 0);
        check("held_hit", num, 8);

        // Saturation at 31.
        for (int i = 0; i < 35; i++) pulse(0, 1, 0);
        cyc(1, 0, 0, 0);
        check("saturate", num, 31);

        // New game: num 4, lives 1, then simultaneous hit+miss ends it.
        cyc(0, 0, 0, 0);
        pulse(1, 0, 0);
        for (int i = 0; i < 4; i++) pulse(0, 1, 0);
        pulse(0, 0, 1);
        pulse(0, 0, 1);
        cyc(1, 0, 0, 0);
        check("pre_num", num, 4);
        check("pre_lives", lives, 1);
        pulse(0, 1, 1);
        check("end_num", num, 5);
        check("end_lives", lives, 0);
        check("end_over", game_over, 1);
        pulse(0, 1, 0);
        cyc(1, 0, 0, 0);
        check("over_hold", num, 5);
        pulse(1, 1, 1);
        cyc(1, 0, 0, 0);
        check("restart_num", num, 0);
        check("restart_lives", lives, 3);
        check("restart_play", playing, 1);

        // Mid-game reset with start held through release.
        for (int i = 0; i < 9; i++) pulse(0, 1, 0);
        cyc(1, 0, 0, 0);
        check("pre_rst", num, 9);
        cyc(0, 1, 0, 0);
        check("midrst_num", num, 0);
        check("midrst_idle", playing, 0);
        cyc(1, 1, 0, 0);
        check("rel_idle", playing, 0);
        for (int i = 0; i < 6; i++) cyc(1, 1, 0, 0);
        check("rel_play", playing, 1);
        cyc(1, 0, 0, 0);

        // Randomized games against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 299) != 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
